// File: rtl/traffic_pkg.sv
// Shared types and lamp-field layout for the intersection signal controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      S_GREEN,
      S_YELLOW,
      S_ALLRED,
      S_FLASH
   } state_t;

   // Each phase owns a LAMP_W-bit field {walk, red, yellow, green}
   localparam int unsigned LAMP_W = 4;
   localparam int unsigned L_GRN  = 0;
   localparam int unsigned L_YEL  = 1;
   localparam int unsigned L_RED  = 2;
   localparam int unsigned L_WALK = 3;

endpackage

// File: rtl/traffic_phase_timer.sv
// Up-counter for per-state dwell timing: synchronous clear, hold (saturate) and target compare.
module traffic_phase_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             hold,
   input  logic [CNT_W-1:0] target,
   output logic [CNT_W-1:0] count,
   output logic             hit
);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins over hold, hold wins over increment
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (!hold) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign hit   = (count_q == target);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach signal controller: green -> yellow -> all-red per phase, round-robin or
// vehicle-actuated, with latched pedestrian walk service and a flashing-red mode.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_PHASES     = 2,
   parameter int unsigned GREEN_CYC      = 10000,
   parameter int unsigned YELLOW_CYC     = 1500,
   parameter int unsigned ALLRED_CYC     = 200,
   parameter int unsigned WALK_CYC       = 4000,
   parameter int unsigned FLASH_HALF_CYC = 500,
   parameter int unsigned ACTUATED       = 0,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_PHASES-1:0]        veh_req,
   input  logic [NUM_PHASES-1:0]        ped_req,
   input  logic                         flash,
   output logic [LAMP_W*NUM_PHASES-1:0] lamps,
   output logic [2:0]                   cur_phase,
   output logic [NUM_PHASES-1:0]        ped_pend
);

   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF_CYC - 1);
   localparam logic [CNT_W:0]   WALK_LIM    = (CNT_W + 1)'(WALK_CYC);

   state_t                  state_q, state_d;
   logic [2:0]              cur_q, cur_d;
   logic [NUM_PHASES-1:0]   ped_q, ped_d;
   logic                    walk_q, walk_d;
   logic                    tgl_q, tgl_d;

   logic                    tmr_clr, tmr_hold, tmr_hit;
   logic [CNT_W-1:0]        tmr_target, tmr_count;

   logic [NUM_PHASES-1:0]   demand, ped_served;
   logic                    other_demand;
   logic [2:0]              nxt_phase;
   logic                    walk_on;

   // First phase after cur (with wrap) that has demand; plain successor in fixed mode.
   // With no demand anywhere else in actuated mode the current phase is re-served.
   function automatic logic [2:0] pick_next(input logic [2:0] cur,
                                            input logic [NUM_PHASES-1:0] dem);
      logic [2:0] nxt;
      logic       found;
      int         j;
      nxt   = (32'(cur) + 1 >= NUM_PHASES) ? 3'd0 : cur + 3'd1;
      found = 1'b0;
      if (ACTUATED != 0) begin
         nxt = cur;
         for (int k = 1; k < NUM_PHASES; k++) begin
            j = int'(cur) + k;
            if (j >= int'(NUM_PHASES)) j = j - int'(NUM_PHASES);
            for (int i = 0; i < NUM_PHASES; i++) begin
               if (!found && i == j && dem[i]) begin
                  nxt   = 3'(i);
                  found = 1'b1;
               end
            end
         end
      end
      return nxt;
   endfunction

   traffic_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .hold   (tmr_hold),
      .target (tmr_target),
      .count  (tmr_count),
      .hit    (tmr_hit)
   );

   // Dwell target for the current state and demand summaries
   always_comb begin
      tmr_target = GREEN_LAST;
      unique case (state_q)
         S_GREEN:  tmr_target = GREEN_LAST;
         S_YELLOW: tmr_target = YELLOW_LAST;
         S_ALLRED: tmr_target = ALLRED_LAST;
         S_FLASH:  tmr_target = FLASH_LAST;
         default:  tmr_target = GREEN_LAST;
      endcase
      demand       = veh_req | ped_q;
      // A press on the very edge of green entry is still served by that green
      ped_served   = ped_q | ped_req;
      other_demand = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (3'(i) != cur_q && demand[i]) other_demand = 1'b1;
      end
      nxt_phase    = pick_next(cur_q, demand);
   end

   // Phase sequencing FSM next-state logic
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      ped_d    = ped_q | ped_req;
      walk_d   = walk_q;
      tgl_d    = tgl_q;
      tmr_clr  = 1'b0;
      tmr_hold = 1'b0;
      unique case (state_q)
         S_GREEN: begin
            if (flash) begin
               state_d = S_YELLOW;
               tmr_clr = 1'b1;
            end else if (tmr_hit) begin
               if (ACTUATED == 0 || other_demand) begin
                  state_d = S_YELLOW;
                  tmr_clr = 1'b1;
               end else begin
                  // Rest in green until someone else asks
                  tmr_hold = 1'b1;
               end
            end
         end
         S_YELLOW: begin
            if (tmr_hit) begin
               tmr_clr = 1'b1;
               if (flash) begin
                  state_d = S_FLASH;
                  tgl_d   = 1'b0;
               end else begin
                  state_d = S_ALLRED;
               end
            end
         end
         S_ALLRED: begin
            if (tmr_hit) begin
               tmr_clr = 1'b1;
               if (flash) begin
                  state_d = S_FLASH;
                  tgl_d   = 1'b0;
               end else begin
                  state_d = S_GREEN;
                  cur_d   = nxt_phase;
                  walk_d  = 1'b0;
                  for (int i = 0; i < NUM_PHASES; i++) begin
                     if (nxt_phase == 3'(i)) begin
                        walk_d   = ped_served[i];
                        ped_d[i] = 1'b0;
                     end
                  end
               end
            end
         end
         S_FLASH: begin
            if (!flash) begin
               state_d = S_ALLRED;
               tmr_clr = 1'b1;
            end else if (tmr_hit) begin
               tmr_clr = 1'b1;
               tgl_d   = ~tgl_q;
            end
         end
         default: begin
            state_d = S_GREEN;
            tmr_clr = 1'b1;
         end
      endcase
   end

   // State, phase, pedestrian latch and flash toggle registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_GREEN;
         cur_q   <= 3'd0;
         ped_q   <= '0;
         walk_q  <= 1'b0;
         tgl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         ped_q   <= ped_d;
         walk_q  <= walk_d;
         tgl_q   <= tgl_d;
      end
   end

   assign walk_on = ({1'b0, tmr_count} < WALK_LIM);

   // Lamp decode straight from registered state and timer
   always_comb begin
      lamps = '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (state_q == S_FLASH) begin
            lamps[LAMP_W*i + L_RED] = ~tgl_q;
         end else if (3'(i) == cur_q) begin
            lamps[LAMP_W*i + L_GRN]  = (state_q == S_GREEN);
            lamps[LAMP_W*i + L_YEL]  = (state_q == S_YELLOW);
            lamps[LAMP_W*i + L_RED]  = (state_q == S_ALLRED);
            lamps[LAMP_W*i + L_WALK] = (state_q == S_GREEN) && walk_q && walk_on;
         end else begin
            lamps[LAMP_W*i + L_RED] = 1'b1;
         end
      end
   end

   assign cur_phase = cur_q;
   assign ped_pend  = ped_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expected lamp/phase/pend values, a negedge
// monitor pops and compares. dut_a: fixed, 2 phases. dut_b: actuated, 4 phases.
module tb_traffic_phase_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, flash_a = 1'b0;
   logic [1:0] veh_a = '0, ped_a = '0;
   logic [7:0] lamps_a;
   logic [2:0] cur_a;
   logic [1:0] pend_a;

   logic        rst_b = 1'b1, flash_b = 1'b0;
   logic [3:0]  veh_b = '0, ped_b = '0;
   logic [15:0] lamps_b;
   logic [2:0]  cur_b;
   logic [3:0]  pend_b;

   typedef struct {
      logic [15:0] lamps;
      logic [2:0]  cur;
      logic [3:0]  pend;
      int          idx;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   checks = 0;
   int   errors = 0;
   int   na = 0;
   int   nb = 0;

   traffic_phase_ctrl #(
      .NUM_PHASES(2), .GREEN_CYC(10), .YELLOW_CYC(3), .ALLRED_CYC(2), .WALK_CYC(4),
      .FLASH_HALF_CYC(5), .ACTUATED(0), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst(rst_a), .veh_req(veh_a), .ped_req(ped_a), .flash(flash_a),
      .lamps(lamps_a), .cur_phase(cur_a), .ped_pend(pend_a)
   );

   traffic_phase_ctrl #(
      .NUM_PHASES(4), .GREEN_CYC(10), .YELLOW_CYC(3), .ALLRED_CYC(2), .WALK_CYC(4),
      .FLASH_HALF_CYC(5), .ACTUATED(1), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst(rst_b), .veh_req(veh_b), .ped_req(ped_b), .flash(flash_b),
      .lamps(lamps_b), .cur_phase(cur_b), .ped_pend(pend_b)
   );

   // Push n cycles of identical expectation for dut_a, advancing one clock each
   task automatic chk_a(input logic [7:0] l, input logic [2:0] c, input logic [1:0] p,
                        input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.lamps = {8'h00, l};
         e.cur   = c;
         e.pend  = {2'b00, p};
         e.idx   = na;
         na++;
         qa.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_b(input logic [15:0] l, input logic [2:0] c, input logic [3:0] p,
                        input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.lamps = l;
         e.cur   = c;
         e.pend  = p;
         e.idx   = nb;
         nb++;
         qb.push_back(e);
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare whatever the stimulus queued for this cycle
   always @(negedge clk) begin
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         checks++;
         if (lamps_a !== ea.lamps[7:0] || cur_a !== ea.cur || pend_a !== ea.pend[1:0]) begin
            errors++;
            $display("FAIL dut_a cycle %0d: got lamps=%h cur=%0d pend=%b, want lamps=%h cur=%0d pend=%b",
                     ea.idx, lamps_a, cur_a, pend_a, ea.lamps[7:0], ea.cur, ea.pend[1:0]);
         end
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         checks++;
         if (lamps_b !== eb.lamps || cur_b !== eb.cur || pend_b !== eb.pend) begin
            errors++;
            $display("FAIL dut_b cycle %0d: got lamps=%h cur=%0d pend=%b, want lamps=%h cur=%0d pend=%b",
                     eb.idx, lamps_b, cur_b, pend_b, eb.lamps, eb.cur, eb.pend);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b0;

      // Fixed round-robin from reset
      chk_a(8'h41, 0, 2'b00, 10);
      chk_a(8'h42, 0, 2'b00, 3);
      chk_a(8'h44, 0, 2'b00, 2);
      chk_a(8'h14, 1, 2'b00, 10);
      chk_a(8'h24, 1, 2'b00, 3);
      chk_a(8'h44, 1, 2'b00, 2);

      // Pedestrian pulse for phase 1 during phase 0 green
      ped_a = 2'b10;
      chk_a(8'h41, 0, 2'b00, 1);
      ped_a = 2'b00;
      chk_a(8'h41, 0, 2'b10, 9);
      chk_a(8'h42, 0, 2'b10, 3);
      chk_a(8'h44, 0, 2'b10, 2);
      chk_a(8'h94, 1, 2'b00, 4);
      chk_a(8'h14, 1, 2'b00, 6);
      chk_a(8'h24, 1, 2'b00, 3);
      chk_a(8'h44, 1, 2'b00, 2);

      // Flash raised mid-green; pedestrian press latched while flashing
      chk_a(8'h41, 0, 2'b00, 3);
      flash_a = 1'b1;
      chk_a(8'h41, 0, 2'b00, 1);
      chk_a(8'h42, 0, 2'b00, 3);
      chk_a(8'h44, 0, 2'b00, 2);
      ped_a = 2'b01;
      chk_a(8'h44, 0, 2'b00, 1);
      ped_a = 2'b00;
      chk_a(8'h44, 0, 2'b01, 2);
      chk_a(8'h00, 0, 2'b01, 5);
      chk_a(8'h44, 0, 2'b01, 1);
      flash_a = 1'b0;
      chk_a(8'h44, 0, 2'b01, 1);
      chk_a(8'h44, 0, 2'b01, 2);
      chk_a(8'h14, 1, 2'b01, 10);
      chk_a(8'h24, 1, 2'b01, 3);
      chk_a(8'h44, 1, 2'b01, 2);
      chk_a(8'h49, 0, 2'b00, 4);
      chk_a(8'h41, 0, 2'b00, 6);
      chk_a(8'h42, 0, 2'b00, 3);
      chk_a(8'h44, 0, 2'b00, 2);

      // Reset mid-yellow of phase 1 with a pending request
      ped_a = 2'b01;
      chk_a(8'h14, 1, 2'b00, 1);
      ped_a = 2'b00;
      chk_a(8'h14, 1, 2'b01, 9);
      chk_a(8'h24, 1, 2'b01, 1);
      rst_a = 1'b1;
      chk_a(8'h24, 1, 2'b01, 1);
      rst_a = 1'b0;
      chk_a(8'h41, 0, 2'b00, 10);
      chk_a(8'h42, 0, 2'b00, 3);

      // Actuated: rest in phase 0 green with no demand
      rst_b = 1'b0;
      chk_b(16'h4441, 0, 4'b0000, 110);
      veh_b = 4'b1000;
      chk_b(16'h4441, 0, 4'b0000, 1);
      chk_b(16'h4442, 0, 4'b0000, 3);
      chk_b(16'h4444, 0, 4'b0000, 2);
      // Phase 3 served; its own demand does not end its green
      chk_b(16'h1444, 3, 4'b0000, 12);
      ped_b = 4'b0010;
      chk_b(16'h1444, 3, 4'b0000, 1);
      ped_b = 4'b0000;
      chk_b(16'h1444, 3, 4'b0010, 1);
      chk_b(16'h2444, 3, 4'b0010, 3);
      chk_b(16'h4444, 3, 4'b0010, 2);
      chk_b(16'h4494, 1, 4'b0000, 4);
      chk_b(16'h4414, 1, 4'b0000, 6);
      chk_b(16'h4424, 1, 4'b0000, 3);

      @(negedge clk);
      #1;
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d queued entries, want 0/0", qa.size(), qb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
